p2m_csi2_glue_gen: RTL and testbench

Parametrised second-generation glue between the Pixel-to-Byte (P2B) stage and the TX D-PHY IP on the CrossLink CSI-2 transmitter. It sequences the D-PHY HS handshake and emits Frame Start/Frame End short packets and long-packet headers, with a configurable data-bus width and data delay. It adds CSI-2 frame numbering, per-frame line counting, an HS-burst timeout and sticky error reporting. The block sits directly between the P2B core and the TX D-PHY, in the byte clock domain.

---
 rtl/p2m_csi2_glue_gen_pkg.sv | 21 ++
 rtl/p2m_csi2_glue_gen_if.sv | 40 ++++
 rtl/p2m_csi2_glue_gen_delay_line.sv | 25 ++
 rtl/p2m_csi2_glue_gen.sv | 156 +++++++++++++++
 tb/tb_p2m_csi2_glue_gen.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p2m_csi2_glue_gen_pkg.sv
// Shared types and constants for the P2B to TX D-PHY CSI-2 glue.
package csi2_glue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_WAIT_HS,
        ST_SP_ASSERT,
        ST_SP_HOLD,
        ST_LP_ASSERT,
        ST_LP_HOLD
    } glue_state_e;

    localparam logic [5:0] FS_DT = 6'h00;
    localparam logic [5:0] FE_DT = 6'h01;

    localparam int unsigned ERR_PROTO = 0;
    localparam int unsigned ERR_LINES = 1;
    localparam int unsigned ERR_TMO   = 2;

endpackage

// File: rtl/p2m_csi2_glue_gen_if.sv
// P2B and TX D-PHY signal bundle; master is the glue side, slave the P2B/PHY side.
interface p2m_csi2_glue_gen_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] p2b_byte_data_i;
    logic              p2b_byte_en_i;
    logic              p2b_fv_start_i;
    logic              p2b_fv_end_i;
    logic              p2b_txfr_req_i;
    logic              p2b_c2d_ready_o;
    logic              p2b_txfr_en_o;
    logic              tx_c2d_ready_i;
    logic              tx_d_hs_rdy_i;
    logic              tx_d_hs_en_o;
    logic              tx_clk_hs_en_o;
    logic              tx_sp_en_o;
    logic              tx_lp_en_o;
    logic              tx_byte_data_en_o;
    logic [DATA_W-1:0] tx_byte_data_o;
    logic [5:0]        tx_dt_o;
    logic [1:0]        tx_vc_o;
    logic [15:0]       tx_wc_o;

    modport master (
        input  p2b_byte_data_i, p2b_byte_en_i, p2b_fv_start_i, p2b_fv_end_i,
               p2b_txfr_req_i, tx_c2d_ready_i, tx_d_hs_rdy_i,
        output p2b_c2d_ready_o, p2b_txfr_en_o, tx_d_hs_en_o, tx_clk_hs_en_o,
               tx_sp_en_o, tx_lp_en_o, tx_byte_data_en_o, tx_byte_data_o,
               tx_dt_o, tx_vc_o, tx_wc_o
    );

    modport slave (
        output p2b_byte_data_i, p2b_byte_en_i, p2b_fv_start_i, p2b_fv_end_i,
               p2b_txfr_req_i, tx_c2d_ready_i, tx_d_hs_rdy_i,
        input  p2b_c2d_ready_o, p2b_txfr_en_o, tx_d_hs_en_o, tx_clk_hs_en_o,
               tx_sp_en_o, tx_lp_en_o, tx_byte_data_en_o, tx_byte_data_o,
               tx_dt_o, tx_vc_o, tx_wc_o
    );

endinterface

// File: rtl/p2m_csi2_glue_gen_delay_line.sv
// Fixed-depth shift register used to align P2B data/enable with the D-PHY header timing.
module csi2_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             byte_clk_i,
    input  logic             reset_byte_n_i,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge byte_clk_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= data_in;
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign data_out = stage[DEPTH-1];

endmodule

// File: rtl/p2m_csi2_glue_gen.sv
// CSI-2 TX glue: D-PHY HS handshake, FS/FE/long-packet headers, frame/line
// counting, HS-burst timeout and sticky error reporting.
module p2m_csi2_glue_gen
    import csi2_glue_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned NUM_PIXELS = 240,
    parameter int unsigned PIX_WIDTH  = 8,
    parameter logic [5:0]  DT         = 6'h2A,
    parameter logic [1:0]  VC         = 2'b00,
    parameter int unsigned DATA_DLY   = 5,
    parameter bit          FNUM_EN    = 1'b1,
    parameter logic [15:0] FNUM_MAX   = 16'hFFFF,
    parameter int unsigned NUM_LINES  = 240,
    parameter int unsigned HS_TMO     = 4095
) (
    input  logic               byte_clk_i,
    input  logic               reset_byte_n_i,
    p2m_csi2_glue_gen_if.master bus,
    input  logic               clr_err_i,
    output logic [15:0]        frame_num_o,
    output logic [15:0]        line_cnt_o,
    output logic [2:0]         err_o
);

    localparam logic [15:0] PAYLOAD_WC = 16'(NUM_PIXELS * PIX_WIDTH / 8);
    localparam int unsigned TMO_W      = (HS_TMO < 2) ? 1 : $clog2(HS_TMO);

    glue_state_e       state_q, state_d;
    logic              is_fe_q, is_fe_d;
    logic [15:0]       fnum_q, lines_q;
    logic [2:0]        err_q, err_set;
    logic [TMO_W-1:0]  tmo_q;
    logic              tmo_hit, fs_accept, lp_accept, in_hold;
    logic              c2d_q, hs_rdy_q;
    logic [5:0]        dt;
    logic [1:0]        vc;
    logic [15:0]       wc;
    logic [DATA_W:0]   dly_in, dly_out;

    assign in_hold = (state_q == ST_SP_HOLD) || (state_q == ST_LP_HOLD);
    assign tmo_hit = (tmo_q == TMO_W'(HS_TMO - 1));

    always_comb begin
        state_d = state_q;
        is_fe_d = is_fe_q;
        err_set = '0;
        unique case (state_q)
            ST_IDLE:      if (bus.tx_c2d_ready_i) state_d = ST_WAIT_REQ;
            ST_WAIT_REQ:  if (bus.p2b_txfr_req_i) state_d = ST_WAIT_HS;
            ST_WAIT_HS: begin
                if (bus.tx_d_hs_rdy_i) begin
                    case ({bus.p2b_fv_start_i, bus.p2b_fv_end_i, bus.p2b_byte_en_i})
                        3'b000: state_d = ST_WAIT_HS;
                        3'b100: begin state_d = ST_SP_ASSERT; is_fe_d = 1'b0; end
                        3'b010: begin
                            state_d = ST_SP_ASSERT;
                            is_fe_d = 1'b1;
                            err_set[ERR_LINES] = (lines_q != 16'(NUM_LINES));
                        end
                        3'b001: state_d = ST_LP_ASSERT;
                        default: begin state_d = ST_IDLE; err_set[ERR_PROTO] = 1'b1; end
                    endcase
                end
            end
            ST_SP_ASSERT: state_d = ST_SP_HOLD;
            ST_LP_ASSERT: state_d = ST_LP_HOLD;
            ST_SP_HOLD, ST_LP_HOLD: begin
                if (!bus.tx_d_hs_rdy_i) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    err_set[ERR_TMO] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fs_accept = (state_q == ST_WAIT_HS) && (state_d == ST_SP_ASSERT) && !is_fe_d;
    assign lp_accept = (state_q == ST_WAIT_HS) && (state_d == ST_LP_ASSERT);

    // Header is purely a function of the current state and latched FS/FE type.
    always_comb begin
        dt = '0;
        vc = '0;
        wc = '0;
        if (state_q == ST_SP_ASSERT || state_q == ST_SP_HOLD) begin
            dt = is_fe_q ? FE_DT : FS_DT;
            vc = VC;
            wc = FNUM_EN ? fnum_q : 16'd0;
        end else if (state_q == ST_LP_ASSERT || state_q == ST_LP_HOLD) begin
            dt = DT;
            vc = VC;
            wc = PAYLOAD_WC;
        end
    end

    always_ff @(posedge byte_clk_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) begin
            state_q  <= ST_IDLE;
            is_fe_q  <= 1'b0;
            fnum_q   <= '0;
            lines_q  <= '0;
            err_q    <= '0;
            tmo_q    <= '0;
            c2d_q    <= 1'b0;
            hs_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_fe_q  <= is_fe_d;
            c2d_q    <= bus.tx_c2d_ready_i;
            hs_rdy_q <= bus.tx_d_hs_rdy_i;
            err_q    <= (clr_err_i ? 3'b000 : err_q) | err_set;
            if (fs_accept) fnum_q <= (fnum_q == FNUM_MAX) ? 16'd1 : fnum_q + 16'd1;
            if (fs_accept) begin
                lines_q <= '0;
            end else if (lp_accept && lines_q != 16'hFFFF) begin
                lines_q <= lines_q + 16'd1;
            end
            if (state_q == ST_SP_ASSERT || state_q == ST_LP_ASSERT) begin
                tmo_q <= '0;
            end else if (in_hold && bus.tx_d_hs_rdy_i && !tmo_hit) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

    assign dly_in = {bus.p2b_byte_en_i, bus.p2b_byte_data_i};

    csi2_delay_line #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DATA_DLY)
    ) u_dly (
        .byte_clk_i     (byte_clk_i),
        .reset_byte_n_i (reset_byte_n_i),
        .data_in        (dly_in),
        .data_out       (dly_out)
    );

    assign bus.p2b_c2d_ready_o   = c2d_q;
    assign bus.p2b_txfr_en_o     = hs_rdy_q;
    assign bus.tx_d_hs_en_o      = (state_q == ST_WAIT_HS);
    assign bus.tx_clk_hs_en_o    = (state_q == ST_WAIT_HS);
    assign bus.tx_sp_en_o        = (state_q == ST_SP_ASSERT);
    assign bus.tx_lp_en_o        = (state_q == ST_LP_ASSERT);
    assign bus.tx_byte_data_en_o = dly_out[DATA_W];
    assign bus.tx_byte_data_o    = dly_out[DATA_W-1:0];
    assign bus.tx_dt_o           = dt;
    assign bus.tx_vc_o           = vc;
    assign bus.tx_wc_o           = wc;
    assign frame_num_o           = fnum_q;
    assign line_cnt_o            = lines_q;
    assign err_o                 = err_q;

endmodule

// File: tb/tb_p2m_csi2_glue_gen.sv
// Randomised packet-level bench for p2m_csi2_glue_gen with a per-cycle output compare.
module tb_p2m_csi2_glue_gen;

    localparam int          DATA_W = 64;
    localparam int          DLY    = 5;
    localparam int          NLINES = 240;
    localparam logic [15:0] FMAX   = 16'd3;
    localparam int          TMO    = 20;
    localparam logic [15:0] PAY    = 16'd240;
    localparam logic [5:0]  LDT    = 6'h2A;
    localparam logic [1:0]  LVC    = 2'b00;
    localparam int K_FS = 0, K_FE = 1, K_LP = 2, K_BAD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] fnum, lines;
    logic [2:0]  err;

    p2m_csi2_glue_gen_if #(.DATA_W(DATA_W)) bus ();

    p2m_csi2_glue_gen #(
        .DATA_W(DATA_W), .NUM_PIXELS(240), .PIX_WIDTH(8), .DT(6'h2A), .VC(2'b00),
        .DATA_DLY(DLY), .FNUM_EN(1'b1), .FNUM_MAX(FMAX), .NUM_LINES(NLINES), .HS_TMO(TMO)
    ) dut (
        .byte_clk_i(clk), .reset_byte_n_i(rst_n), .bus(bus), .clr_err_i(clr),
        .frame_num_o(fnum), .line_cnt_o(lines), .err_o(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected outputs for the current cycle, maintained by the driver.
    logic        exp_hs, exp_sp, exp_lp;
    logic [5:0]  exp_dt;
    logic [1:0]  exp_vc;
    logic [15:0] exp_wc, exp_fnum, exp_lines;
    logic [2:0]  exp_err;
    int          beats_left = 0;

    logic [64:0] hist [16];
    logic        prev_c2d = 1'b0, prev_hs = 1'b0, prev_den = 1'b0;
    int          cyc = 0, last_lp = -100, last_gap = -1, sp_cnt = 0, lp_cnt = 0;
    logic [15:0] last_sp_wc = '0;
    logic [15:0] fs_wc [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [64:0] w;
        w = rst_n ? hist[DLY-1] : 65'd0;
        check("c2d_ready", 64'(bus.p2b_c2d_ready_o), rst_n ? 64'(prev_c2d) : 64'd0);
        check("txfr_en",   64'(bus.p2b_txfr_en_o),   rst_n ? 64'(prev_hs)  : 64'd0);
        check("d_hs_en",   64'(bus.tx_d_hs_en_o),    64'(exp_hs));
        check("clk_hs_en", 64'(bus.tx_clk_hs_en_o),  64'(exp_hs));
        check("sp_en",     64'(bus.tx_sp_en_o),      64'(exp_sp));
        check("lp_en",     64'(bus.tx_lp_en_o),      64'(exp_lp));
        check("dt",        64'(bus.tx_dt_o),         64'(exp_dt));
        check("vc",        64'(bus.tx_vc_o),         64'(exp_vc));
        check("wc",        64'(bus.tx_wc_o),         64'(exp_wc));
        check("frame_num", 64'(fnum),                64'(exp_fnum));
        check("line_cnt",  64'(lines),               64'(exp_lines));
        check("err",       64'(err),                 64'(exp_err));
        check("data_en",   64'(bus.tx_byte_data_en_o), 64'(w[64]));
        check("data",      bus.tx_byte_data_o,       w[63:0]);
        if (bus.tx_lp_en_o) begin last_lp = cyc; lp_cnt++; end
        if (bus.tx_byte_data_en_o && !prev_den) last_gap = cyc - last_lp;
        if (bus.tx_sp_en_o) begin
            sp_cnt++;
            last_sp_wc = bus.tx_wc_o;
            if (bus.tx_dt_o == 6'h00) fs_wc.push_back(bus.tx_wc_o);
        end
        prev_den = bus.tx_byte_data_en_o;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) hist[i] = '0;
        end else begin
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {bus.p2b_byte_en_i, bus.p2b_byte_data_i};
        end
        prev_c2d = rst_n ? bus.tx_c2d_ready_i : 1'b0;
        prev_hs  = rst_n ? bus.tx_d_hs_rdy_i  : 1'b0;
        cyc++;
    end

    task automatic set_idle();
        exp_hs = 0; exp_sp = 0; exp_lp = 0; exp_dt = '0; exp_vc = '0; exp_wc = '0;
    endtask

    // Advance one cycle; a pending clear wipes the expected errors before new sets are applied.
    task automatic step();
        logic c;
        c = clr;
        @(posedge clk);
        #1;
        if (c) begin exp_err = '0; clr = 1'b0; end
        if (beats_left > 0) begin bus.p2b_byte_en_i = 1'b1; beats_left--; end
        else bus.p2b_byte_en_i = 1'b0;
        bus.p2b_byte_data_i = {$urandom, $urandom};
    endtask

    // Called in IDLE or WAIT_REQ with all P2B flags low and c2d_ready high.
    task automatic run_pkt(input int kind, input int hold, input bit tmo, input bit clr_at, input int nb);
        logic [2:0]  b;
        logic [15:0] nf;
        step();
        bus.p2b_txfr_req_i = 1'b1;
        step();
        bus.p2b_txfr_req_i = 1'b0;
        exp_hs = 1;
        repeat ($urandom_range(0, 3)) begin
            bus.tx_d_hs_rdy_i = 1'($urandom_range(0, 1));
            step();
        end
        bus.tx_d_hs_rdy_i = 1'b1;
        clr = clr_at;
        case (kind)
            K_FS: bus.p2b_fv_start_i = 1'b1;
            K_FE: bus.p2b_fv_end_i = 1'b1;
            K_LP: begin bus.p2b_byte_en_i = 1'b1; beats_left = nb - 1; end
            default: begin
                case ($urandom_range(0, 3))
                    0: b = 3'b110;
                    1: b = 3'b101;
                    2: b = 3'b011;
                    default: b = 3'b111;
                endcase
                bus.p2b_fv_start_i = b[2];
                bus.p2b_fv_end_i = b[1];
                bus.p2b_byte_en_i = b[0];
            end
        endcase
        step();
        bus.p2b_fv_start_i = 1'b0;
        bus.p2b_fv_end_i = 1'b0;
        exp_hs = 0;
        if (kind == K_BAD) begin
            exp_err[0] = 1'b1;
            bus.tx_d_hs_rdy_i = 1'b0;
            return;
        end
        if (kind == K_FS) begin
            nf = (exp_fnum == FMAX) ? 16'd1 : exp_fnum + 16'd1;
            exp_fnum = nf; exp_lines = 0;
            exp_sp = 1; exp_dt = 6'h00; exp_vc = LVC; exp_wc = nf;
        end else if (kind == K_FE) begin
            if (exp_lines != 16'(NLINES)) exp_err[1] = 1'b1;
            exp_sp = 1; exp_dt = 6'h01; exp_vc = LVC; exp_wc = exp_fnum;
        end else begin
            if (exp_lines != 16'hFFFF) exp_lines = exp_lines + 16'd1;
            exp_lp = 1; exp_dt = LDT; exp_vc = LVC; exp_wc = PAY;
        end
        step();
        exp_sp = 0; exp_lp = 0;
        if (tmo) begin
            repeat (TMO) step();
            set_idle();
            exp_err[2] = 1'b1;
            bus.tx_d_hs_rdy_i = 1'b0;
        end else begin
            repeat (hold) step();
            bus.tx_d_hs_rdy_i = 1'b0;
            step();
            set_idle();
        end
    endtask

    task automatic run_lines(input int n);
        int h;
        for (int i = 0; i < n; i++) begin
            h = $urandom_range(0, 5);
            run_pkt(K_LP, h, 1'b0, 1'b0, $urandom_range(1, h + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp_before, lp_before, k, h;
        logic [15:0] want_fs [5];
        want_fs = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd2};
        bus.p2b_byte_data_i = '0; bus.p2b_byte_en_i = 0; bus.p2b_fv_start_i = 0;
        bus.p2b_fv_end_i = 0; bus.p2b_txfr_req_i = 0; bus.tx_c2d_ready_i = 0; bus.tx_d_hs_rdy_i = 0;
        set_idle(); exp_fnum = '0; exp_lines = '0; exp_err = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_frame_num", 64'(fnum), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_sp_lp", 64'({bus.tx_sp_en_o, bus.tx_lp_en_o}), 64'd0);
        check("rst_wc", 64'(bus.tx_wc_o), 64'd0);
        bus.tx_c2d_ready_i = 1'b1;

        run_pkt(K_FS, 4, 0, 0, 1);
        check("fs1_wc", 64'(last_sp_wc), 64'd1);
        check("fs1_frame_num", 64'(fnum), 64'd1);
        run_pkt(K_LP, 6, 0, 0, 3);
        check("lp_first_data_gap", 64'(last_gap), 64'd4);
        check("lp1_line_cnt", 64'(lines), 64'd1);
        run_lines(NLINES - 1);
        run_pkt(K_FE, 3, 0, 0, 1);
        check("fe1_wc", 64'(last_sp_wc), 64'd1);
        check("fe1_err", 64'(err), 64'd0);

        run_pkt(K_FS, 2, 0, 0, 1);
        run_lines(NLINES - 1);
        run_pkt(K_FE, 2, 0, 0, 1);
        check("fe2_wc", 64'(last_sp_wc), 64'd2);
        check("fe2_err", 64'(err), 64'd2);
        clr = 1'b1;
        step();
        check("clr_err", 64'(err), 64'd0);

        run_pkt(K_FE, 1, 0, 0, 1);
        sp_before = sp_cnt; lp_before = lp_cnt;
        run_pkt(K_BAD, 0, 0, 1, 1);
        step();
        check("bad_clr_err", 64'(err), 64'd1);
        check("bad_no_sp", 64'(sp_cnt), 64'(sp_before));
        check("bad_no_lp", 64'(lp_cnt), 64'(lp_before));
        run_pkt(K_FE, 1, 0, 1, 1);
        check("fe_clr_same_cycle", 64'(err), 64'd2);

        run_pkt(K_FS, 1, 0, 0, 1);
        run_pkt(K_FS, 1, 0, 0, 1);
        run_pkt(K_FS, 1, 0, 0, 1);
        check("fs_count", 64'(fs_wc.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < fs_wc.size()) check("fs_wc_seq", 64'(fs_wc[i]), 64'(want_fs[i]));

        clr = 1'b1;
        run_pkt(K_LP, 0, 1, 0, 2);
        check("tmo_err", 64'(err), 64'd4);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            k = (k < 2) ? K_FS : (k < 4) ? K_FE : (k < 9) ? K_LP : K_BAD;
            h = $urandom_range(0, 15);
            run_pkt(k, h, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(1, h + 1));
        end

        // Reset in the middle of a long packet.
        step();
        bus.p2b_txfr_req_i = 1'b1;
        step();
        bus.p2b_txfr_req_i = 1'b0;
        exp_hs = 1;
        bus.tx_d_hs_rdy_i = 1'b1;
        bus.p2b_byte_en_i = 1'b1;
        beats_left = 2;
        step();
        exp_hs = 0; exp_lp = 1; exp_dt = LDT; exp_vc = LVC; exp_wc = PAY;
        if (exp_lines != 16'hFFFF) exp_lines = exp_lines + 16'd1;
        step();
        exp_lp = 0;
        step();
        #2;
        rst_n = 1'b0;
        set_idle(); exp_fnum = '0; exp_lines = '0; exp_err = '0;
        beats_left = 0; bus.p2b_byte_en_i = 1'b0; bus.tx_d_hs_rdy_i = 1'b0;
        #1;
        check("rstmid_dt_wc", 64'({bus.tx_dt_o, bus.tx_wc_o}), 64'd0);
        check("rstmid_ctrl", 64'({bus.tx_d_hs_en_o, bus.tx_sp_en_o, bus.tx_lp_en_o,
                                  bus.p2b_c2d_ready_o, bus.p2b_txfr_en_o}), 64'd0);
        check("rstmid_data", bus.tx_byte_data_o, 64'd0);
        check("rstmid_data_en", 64'(bus.tx_byte_data_en_o), 64'd0);
        check("rstmid_counts", 64'({fnum, lines}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_pkt(K_FE, 2, 0, 0, 1);
        check("fe_no_fs_wc", 64'(last_sp_wc), 64'd0);
        check("fe_no_fs_err", 64'(err), 64'd2);
        run_pkt(K_FS, 2, 0, 0, 1);
        check("fs_after_rst", 64'(fnum), 64'd1);
        run_lines(5);
        repeat (DLY + 2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
